// File: rtl/mux41_rr_sched.sv
// mux41_rr_sched
// Round-robin scheduler that time-shares a 4:1 single-bit mux among four
// requesters. Requests are level sensitive; a grant is held while the owner
// keeps requesting, but for at most HOLD_MAX consecutive cycles whenever
// another requester is waiting.
//
// Parameters:
//   HOLD_MAX : max consecutive grant cycles per owner under contention (1..255)
//
// Ports:
//   CLK     : clock, all state updates on the rising edge
//   RST     : synchronous active-high reset
//   REQ     : [3:0] level request, REQ[i] = requester i wants the mux
//   GNT     : [3:0] registered one-hot grant, or all zero when idle
//   SEL     : [1:0] registered owner index, drives the mux select
//   VALID   : registered, high while GNT is non-zero
//   TIMEOUT : registered one-cycle pulse on a HOLD_MAX revocation
module mux41_rr_sched #(
  parameter int HOLD_MAX = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] REQ,
  output logic [3:0] GNT,
  output logic [1:0] SEL,
  output logic       VALID,
  output logic       TIMEOUT
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Counter value marking the last cycle of an owner's window.
  localparam logic [7:0] CNT_LAST = 8'(HOLD_MAX - 1);

  logic [0:0] state_q, state_d;
  logic [1:0] last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic       valid_q, valid_d;
  logic       timeout_q, timeout_d;

  logic [2:0] pick_all;
  logic [2:0] pick_others;
  logic [3:0] others;

  // Round-robin search from last+1 up to last itself (k = 4 wraps to last).
  // Iterating downwards lets the lowest offset win by overwriting.
  function automatic logic [2:0] rr_pick(input logic [3:0] elig,
                                         input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (elig[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Two candidate winners are always computed: one over all requests (idle
  // start or voluntary release) and one excluding the current owner (timeout).
  always_comb begin
    others      = REQ & ~(4'b0001 << last_q);
    pick_all    = rr_pick(REQ, last_q);
    pick_others = rr_pick(others, last_q);
  end

  // Next-state logic. In GRANT the owner is always last_q, since last_q is
  // loaded with the winner on every grant. SEL is left untouched on the way
  // to IDLE so the mux output does not glitch.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_all[2]) begin
          state_d = ST_GRANT;
          last_d  = pick_all[1:0];
          sel_d   = pick_all[1:0];
          gnt_d   = 4'b0001 << pick_all[1:0];
          cnt_d   = 8'd0;
          valid_d = 1'b1;
        end
      end

      default: begin
        if (!REQ[last_q]) begin
          if (pick_all[2]) begin
            last_d  = pick_all[1:0];
            sel_d   = pick_all[1:0];
            gnt_d   = 4'b0001 << pick_all[1:0];
            cnt_d   = 8'd0;
            valid_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
            cnt_d   = 8'd0;
            valid_d = 1'b0;
          end
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = 8'd0;
          if (pick_others[2]) begin
            last_d    = pick_others[1:0];
            sel_d     = pick_others[1:0];
            gnt_d     = 4'b0001 << pick_others[1:0];
            timeout_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  // State registers. last resets to 3 so requester 0 has first priority.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      last_q    <= 2'b11;
      cnt_q     <= 8'd0;
      gnt_q     <= 4'b0000;
      sel_q     <= 2'b00;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign GNT     = gnt_q;
  assign SEL     = sel_q;
  assign VALID   = valid_q;
  assign TIMEOUT = timeout_q;

endmodule

// File: tb/tb_mux41_rr_sched.sv
// tb_mux41_rr_sched
// Directed bench for mux41_rr_sched: one instance with the default window
// of 8 cycles and one built with a window of 1 cycle.
module tb_mux41_rr_sched;

  logic       clk;
  logic       rst, rst1;
  logic [3:0] req, req1;
  logic [3:0] gnt, gnt1;
  logic [1:0] sel, sel1;
  logic       valid, valid1;
  logic       timeout, timeout1;

  int total;
  int bad;

  mux41_rr_sched #(.HOLD_MAX(8)) dut (
    .CLK(clk), .RST(rst), .REQ(req),
    .GNT(gnt), .SEL(sel), .VALID(valid), .TIMEOUT(timeout)
  );

  mux41_rr_sched #(.HOLD_MAX(1)) dut1 (
    .CLK(clk), .RST(rst1), .REQ(req1),
    .GNT(gnt1), .SEL(sel1), .VALID(valid1), .TIMEOUT(timeout1)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle; inputs set afterwards apply to the
  // next edge, and outputs read afterwards are those of the edge just taken.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    step();
    step();
    total++;
    if (gnt !== 4'b0000) begin bad++; $display("[TB] FAIL reset_gnt got=%b exp=0000", gnt); end
    total++;
    if (sel !== 2'b00) begin bad++; $display("[TB] FAIL reset_sel got=%b exp=00", sel); end
    total++;
    if (valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b exp=0", valid); end
    total++;
    if (timeout !== 1'b0) begin bad++; $display("[TB] FAIL reset_timeout got=%b exp=0", timeout); end
    rst = 1'b0;
  endtask

  // All four requesting: 8 cycles each in order 0,1,2,3,0 with a timeout
  // pulse on the first cycle of every handoff.
  task automatic test_rotation();
    logic [3:0] exp_gnt;
    logic       exp_to;
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 8; c++) begin
        step();
        exp_gnt = 4'b0001 << (k % 4);
        exp_to  = (c == 0) && (k > 0);
        total++;
        if (gnt !== exp_gnt)
          begin bad++; $display("[TB] FAIL rot_gnt k=%0d c=%0d got=%b exp=%b", k, c, gnt, exp_gnt); end
        total++;
        if (sel !== 2'(k % 4))
          begin bad++; $display("[TB] FAIL rot_sel k=%0d c=%0d got=%0d exp=%0d", k, c, sel, k % 4); end
        total++;
        if (timeout !== exp_to)
          begin bad++; $display("[TB] FAIL rot_timeout k=%0d c=%0d got=%b exp=%b", k, c, timeout, exp_to); end
        total++;
        if (valid !== 1'b1)
          begin bad++; $display("[TB] FAIL rot_valid k=%0d c=%0d got=%b exp=1", k, c, valid); end
      end
    end
    req = 4'b0000;
    step();
    total++;
    if (gnt !== 4'b0000 || valid !== 1'b0)
      begin bad++; $display("[TB] FAIL rot_idle gnt=%b valid=%b exp=0000/0", gnt, valid); end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 20; c++) begin
      step();
      total++;
      if (gnt !== 4'b0100 || sel !== 2'b10 || valid !== 1'b1 || timeout !== 1'b0)
        begin bad++; $display("[TB] FAIL single c=%0d gnt=%b sel=%b valid=%b to=%b exp=0100/10/1/0", c, gnt, sel, valid, timeout); end
    end
    req = 4'b0000;
    step();
    total++;
    if (gnt !== 4'b0000 || sel !== 2'b10 || valid !== 1'b0)
      begin bad++; $display("[TB] FAIL single_drop gnt=%b sel=%b valid=%b exp=0000/10/0", gnt, sel, valid); end
  endtask

  // Owner 1 releases after 3 cycles while 3 waits: direct handoff, no timeout.
  task automatic test_handoff();
    do_reset();
    req = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (gnt !== 4'b0010)
        begin bad++; $display("[TB] FAIL handoff_own c=%0d got=%b exp=0010", c, gnt); end
    end
    req = 4'b1000;
    step();
    total++;
    if (gnt !== 4'b1000 || sel !== 2'b11 || valid !== 1'b1 || timeout !== 1'b0)
      begin bad++; $display("[TB] FAIL handoff gnt=%b sel=%b valid=%b to=%b exp=1000/11/1/0", gnt, sel, valid, timeout); end
  endtask

  task automatic test_wrap();
    do_reset();
    req = 4'b0101;
    step();
    total++;
    if (gnt !== 4'b0001)
      begin bad++; $display("[TB] FAIL wrap_first got=%b exp=0001", gnt); end
    step();
    total++;
    if (gnt !== 4'b0001)
      begin bad++; $display("[TB] FAIL wrap_hold got=%b exp=0001", gnt); end
    req = 4'b0100;
    step();
    total++;
    if (gnt !== 4'b0100 || sel !== 2'b10 || timeout !== 1'b0)
      begin bad++; $display("[TB] FAIL wrap_second gnt=%b sel=%b to=%b exp=0100/10/0", gnt, sel, timeout); end
  endtask

  task automatic test_hold1();
    logic [3:0] exp_gnt;
    rst1 = 1'b1;
    req1 = 4'b0000;
    step();
    rst1 = 1'b0;
    req1 = 4'b0011;
    for (int c = 0; c < 6; c++) begin
      step();
      exp_gnt = (c % 2 == 0) ? 4'b0001 : 4'b0010;
      total++;
      if (gnt1 !== exp_gnt)
        begin bad++; $display("[TB] FAIL hold1_gnt c=%0d got=%b exp=%b", c, gnt1, exp_gnt); end
      total++;
      if (timeout1 !== (c != 0))
        begin bad++; $display("[TB] FAIL hold1_timeout c=%0d got=%b exp=%b", c, timeout1, c != 0); end
    end
    // Owner is 1 here; it releases and 2 takes over, then keeps it alone.
    req1 = 4'b0100;
    step();
    total++;
    if (gnt1 !== 4'b0100 || timeout1 !== 1'b0)
      begin bad++; $display("[TB] FAIL hold1_release gnt=%b to=%b exp=0100/0", gnt1, timeout1); end
    step();
    total++;
    if (gnt1 !== 4'b0100 || timeout1 !== 1'b0)
      begin bad++; $display("[TB] FAIL hold1_alone gnt=%b to=%b exp=0100/0", gnt1, timeout1); end
  endtask

  // Reset during the 4th cycle of owner 1's window, then restart at 0.
  task automatic test_reset_mid();
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 12; c++) step();
    total++;
    if (gnt !== 4'b0010)
      begin bad++; $display("[TB] FAIL mid_pre got=%b exp=0010", gnt); end
    rst = 1'b1;
    step();
    total++;
    if (gnt !== 4'b0000 || sel !== 2'b00 || valid !== 1'b0 || timeout !== 1'b0)
      begin bad++; $display("[TB] FAIL mid_reset gnt=%b sel=%b valid=%b to=%b exp=0000/00/0/0", gnt, sel, valid, timeout); end
    rst = 1'b0;
    step();
    total++;
    if (gnt !== 4'b0001 || sel !== 2'b00 || valid !== 1'b1 || timeout !== 1'b0)
      begin bad++; $display("[TB] FAIL mid_restart gnt=%b sel=%b valid=%b to=%b exp=0001/00/1/0", gnt, sel, valid, timeout); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    rst1  = 1'b1;
    req   = 4'b0000;
    req1  = 4'b0000;
    test_reset();
    test_rotation();
    test_single();
    test_handoff();
    test_wrap();
    test_hold1();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
